// File: rtl/lnl_spi_loader.sv
// Serial program loader: collects 16-bit words from a clk-sampled SPI stream,
// treats the first word of a frame as a header (load address + run flag),
// writes every later word to consecutive memory addresses and optionally
// releases the CPU with a start PC when the frame closes cleanly.
module lnl_spi_loader #(
   parameter int ADDR_W      = 12,
   parameter int DATA_W      = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              spi_din,
   input  logic              spi_csn,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              cpu_hold,
   output logic              boot_go,
   output logic [ADDR_W-1:0] boot_pc,
   output logic              load_err
);

   localparam int CNT_W = $clog2(DATA_W);

   typedef enum logic [1:0] {
      S_IDLE,
      S_HDR,
      S_DATA,
      S_END
   } state_t;

   logic [SYNC_STAGES-1:0] dinSync_q;
   logic [SYNC_STAGES-1:0] csnSync_q;
   logic                   din_s;
   logic                   csn_s;

   state_t              state_q,     state_d;
   logic [DATA_W-1:0]   shift_q,     shift_d;
   logic [CNT_W-1:0]    bitCnt_q,    bitCnt_d;
   logic [ADDR_W-1:0]   addrCnt_q,   addrCnt_d;
   logic                run_q,       run_d;
   logic                goPend_q,    goPend_d;
   logic                memWe_q,     memWe_d;
   logic [ADDR_W-1:0]   memAddr_q,   memAddr_d;
   logic [DATA_W-1:0]   memWdata_q,  memWdata_d;
   logic                cpuHold_q,   cpuHold_d;
   logic                bootGo_q,    bootGo_d;
   logic [ADDR_W-1:0]   bootPc_q,    bootPc_d;
   logic                loadErr_q,   loadErr_d;

   // Synchronizer chains; chip-select idles deasserted so reset looks like "no frame".
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dinSync_q <= '0;
         csnSync_q <= '1;
      end else begin
         dinSync_q[0] <= spi_din;
         csnSync_q[0] <= spi_csn;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            dinSync_q[i] <= dinSync_q[i-1];
            csnSync_q[i] <= csnSync_q[i-1];
         end
      end
   end

   assign din_s = dinSync_q[SYNC_STAGES-1];
   assign csn_s = csnSync_q[SYNC_STAGES-1];

   // Frame FSM: next state, word assembly, write strobe and boot handshake.
   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bitCnt_d   = bitCnt_q;
      addrCnt_d  = addrCnt_q;
      run_d      = run_q;
      goPend_d   = goPend_q;
      memWe_d    = 1'b0;
      memAddr_d  = memAddr_q;
      memWdata_d = memWdata_q;
      cpuHold_d  = cpuHold_q;
      bootGo_d   = 1'b0;
      bootPc_d   = bootPc_q;
      loadErr_d  = loadErr_q;

      case (state_q)
         S_IDLE: begin
            if (!csn_s) begin
               state_d   = S_HDR;
               cpuHold_d = 1'b1;
               loadErr_d = 1'b0;
               bitCnt_d  = '0;
               goPend_d  = 1'b0;
            end
         end
         S_HDR, S_DATA: begin
            if (csn_s) begin
               state_d   = S_END;
               loadErr_d = (state_q == S_HDR) || (bitCnt_q != '0);
               goPend_d  = run_q && (state_q == S_DATA) && (bitCnt_q == '0);
            end else begin
               shift_d  = {shift_q[DATA_W-2:0], din_s};
               bitCnt_d = bitCnt_q + 1'b1;
               if (bitCnt_q == CNT_W'(DATA_W-1)) begin
                  bitCnt_d = '0;
                  if (state_q == S_HDR) begin
                     addrCnt_d = shift_d[ADDR_W-1:0];
                     bootPc_d  = shift_d[ADDR_W-1:0];
                     run_d     = shift_d[DATA_W-1];
                     state_d   = S_DATA;
                  end else begin
                     memWe_d    = 1'b1;
                     memAddr_d  = addrCnt_q;
                     memWdata_d = shift_d;
                     addrCnt_d  = addrCnt_q + 1'b1;
                  end
               end
            end
         end
         S_END: begin
            state_d   = S_IDLE;
            cpuHold_d = 1'b0;
            bootGo_d  = goPend_q;
            goPend_d  = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers; reset clears everything, memory is left untouched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         shift_q    <= '0;
         bitCnt_q   <= '0;
         addrCnt_q  <= '0;
         run_q      <= 1'b0;
         goPend_q   <= 1'b0;
         memWe_q    <= 1'b0;
         memAddr_q  <= '0;
         memWdata_q <= '0;
         cpuHold_q  <= 1'b0;
         bootGo_q   <= 1'b0;
         bootPc_q   <= '0;
         loadErr_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bitCnt_q   <= bitCnt_d;
         addrCnt_q  <= addrCnt_d;
         run_q      <= run_d;
         goPend_q   <= goPend_d;
         memWe_q    <= memWe_d;
         memAddr_q  <= memAddr_d;
         memWdata_q <= memWdata_d;
         cpuHold_q  <= cpuHold_d;
         bootGo_q   <= bootGo_d;
         bootPc_q   <= bootPc_d;
         loadErr_q  <= loadErr_d;
      end
   end

   assign mem_we    = memWe_q;
   assign mem_addr  = memAddr_q;
   assign mem_wdata = memWdata_q;
   assign cpu_hold  = cpuHold_q;
   assign boot_go   = bootGo_q;
   assign boot_pc   = bootPc_q;
   assign load_err  = loadErr_q;

endmodule

// File: tb/tb_lnl_spi_loader.sv
// Bench for the serial program loader: frames are built from word lists and
// the expected memory writes / boot behaviour are derived from frame contents.
module tb_lnl_spi_loader;

   logic        clk;
   logic        rst_n;
   logic        spi_din;
   logic        spi_csn;
   logic        mem_we;
   logic [11:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        cpu_hold;
   logic        boot_go;
   logic [11:0] boot_pc;
   logic        load_err;

   int tests;
   int failures;
   int cycle;
   int bootCount;
   int bootHoldBad;

   logic [11:0] wrAddrQ[$];
   logic [15:0] wrDataQ[$];
   int          wrCycQ[$];
   logic [15:0] frameWords[$];

   lnl_spi_loader #(.ADDR_W(12), .DATA_W(16), .SYNC_STAGES(2)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .spi_din  (spi_din),
      .spi_csn  (spi_csn),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .cpu_hold (cpu_hold),
      .boot_go  (boot_go),
      .boot_pc  (boot_pc),
      .load_err (load_err)
   );

   // 10 ns system clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle counter used to measure spacing between writes
   always @(posedge clk) cycle <= cycle + 1;

   // Observe the memory and CPU side away from the active edge
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         wrAddrQ.push_back(mem_addr);
         wrDataQ.push_back(mem_wdata);
         wrCycQ.push_back(cycle);
      end
      if (boot_go === 1'b1) begin
         bootCount = bootCount + 1;
         if (cpu_hold !== 1'b0) bootHoldBad = bootHoldBad + 1;
      end
   end

   task automatic clearMonitor();
      wrAddrQ.delete();
      wrDataQ.delete();
      wrCycQ.delete();
      bootCount   = 0;
      bootHoldBad = 0;
   endtask

   // Drive the n most significant bits of w, one bit per clock
   task automatic driveBits(input logic [15:0] w, input int n);
      for (int i = 0; i < n; i++) begin
         spi_din = w[15-i];
         @(negedge clk);
      end
   endtask

   // Chip-select low plus the one idle cycle the loader spends noticing it
   task automatic startFrame();
      @(negedge clk);
      spi_csn = 1'b0;
      spi_din = 1'b0;
      @(negedge clk);
   endtask

   task automatic endFrame();
      spi_csn = 1'b1;
      spi_din = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   task automatic checkAllZero(input string name);
      tests++;
      if ({mem_we, mem_addr, mem_wdata, cpu_hold, boot_go, boot_pc, load_err} !== '0) begin
         failures++;
         $display("[TB] FAIL %s: outputs we=%b addr=%h data=%h hold=%b go=%b pc=%h err=%b, all required 0",
                  name, mem_we, mem_addr, mem_wdata, cpu_hold, boot_go, boot_pc, load_err);
      end
   endtask

   // Sends header hdr, then frameWords, then `extra` stray bits; checks against the frame rules
   task automatic runFrame(input string name, input logic [15:0] hdr, input int extra);
      logic        expErr;
      logic        expBoot;
      logic [11:0] expAddr;
      logic [15:0] junk;
      clearMonitor();
      startFrame();
      driveBits(hdr, 16);
      tests++;
      if (cpu_hold !== 1'b1) begin
         failures++;
         $display("[TB] FAIL %s hold_in_frame: cpu_hold=%b required 1", name, cpu_hold);
      end
      tests++;
      if (load_err !== 1'b0) begin
         failures++;
         $display("[TB] FAIL %s err_cleared_at_start: load_err=%b required 0", name, load_err);
      end
      foreach (frameWords[i]) driveBits(frameWords[i], 16);
      junk = 16'($urandom);
      driveBits(junk, extra);
      endFrame();

      expErr  = (extra != 0);
      expBoot = !expErr && hdr[15];

      tests++;
      if (wrAddrQ.size() != frameWords.size()) begin
         failures++;
         $display("[TB] FAIL %s write_count: got %0d required %0d", name, wrAddrQ.size(), frameWords.size());
      end else begin
         for (int i = 0; i < frameWords.size(); i++) begin
            expAddr = 12'((int'(hdr[11:0]) + i) % 4096);
            tests++;
            if (wrAddrQ[i] !== expAddr || wrDataQ[i] !== frameWords[i]) begin
               failures++;
               $display("[TB] FAIL %s write%0d: addr=%h data=%h required addr=%h data=%h",
                        name, i, wrAddrQ[i], wrDataQ[i], expAddr, frameWords[i]);
            end
            if (i > 0) begin
               tests++;
               if (wrCycQ[i] - wrCycQ[i-1] != 16) begin
                  failures++;
                  $display("[TB] FAIL %s write_spacing%0d: got %0d cycles required 16",
                           name, i, wrCycQ[i] - wrCycQ[i-1]);
               end
            end
         end
      end
      tests++;
      if (bootCount != (expBoot ? 1 : 0)) begin
         failures++;
         $display("[TB] FAIL %s boot_go_count: got %0d required %0d", name, bootCount, expBoot ? 1 : 0);
      end
      tests++;
      if (bootHoldBad != 0) begin
         failures++;
         $display("[TB] FAIL %s boot_with_hold: %0d boot_go cycles with cpu_hold high, required 0", name, bootHoldBad);
      end
      tests++;
      if (boot_pc !== hdr[11:0]) begin
         failures++;
         $display("[TB] FAIL %s boot_pc: got %h required %h", name, boot_pc, hdr[11:0]);
      end
      tests++;
      if (load_err !== expErr) begin
         failures++;
         $display("[TB] FAIL %s load_err: got %b required %b", name, load_err, expErr);
      end
      tests++;
      if (cpu_hold !== 1'b0) begin
         failures++;
         $display("[TB] FAIL %s hold_released: cpu_hold=%b required 0", name, cpu_hold);
      end
   endtask

   task automatic test_reset();
      rst_n   = 1'b0;
      spi_csn = 1'b1;
      spi_din = 1'b0;
      clearMonitor();
      repeat (3) @(negedge clk);
      checkAllZero("reset_asserted");
      rst_n = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         checkAllZero("reset_idle");
      end
      tests++;
      if (wrAddrQ.size() != 0) begin
         failures++;
         $display("[TB] FAIL reset_no_write: got %0d writes required 0", wrAddrQ.size());
      end
   endtask

   task automatic test_basic_frame();
      frameWords = {16'h7800, 16'hF200};
      runFrame("basic", 16'h8010, 0);
   endtask

   task automatic test_wrap();
      frameWords = {16'h1111, 16'h2222};
      runFrame("wrap", 16'h0FFF, 0);
   endtask

   task automatic test_partial();
      frameWords.delete();
      runFrame("partial", 16'h8020, 9);
   endtask

   task automatic test_header_only();
      frameWords.delete();
      runFrame("hdr_only", 16'h8123, 0);
   endtask

   task automatic test_random();
      logic [15:0] hdr;
      int          n;
      int          extra;
      for (int f = 0; f < 6; f++) begin
         hdr = 16'($urandom);
         n   = $urandom_range(0, 4);
         extra = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 15) : 0;
         frameWords.delete();
         for (int i = 0; i < n; i++) frameWords.push_back(16'($urandom));
         runFrame($sformatf("rand%0d", f), hdr, extra);
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [15:0] w0;
      logic [15:0] w1;
      w0 = 16'($urandom);
      w1 = 16'($urandom);
      clearMonitor();
      startFrame();
      driveBits(16'h8200, 16);
      driveBits(w0, 16);
      driveBits(w1, 8);
      tests++;
      if (wrAddrQ.size() != 1) begin
         failures++;
         $display("[TB] FAIL midreset_first_write: got %0d writes required 1", wrAddrQ.size());
      end
      rst_n = 1'b0;
      #1;
      checkAllZero("midreset_async");
      clearMonitor();
      spi_csn = 1'b1;
      spi_din = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(negedge clk);
      tests++;
      if (wrAddrQ.size() != 0 || bootCount != 0) begin
         failures++;
         $display("[TB] FAIL midreset_quiet: writes=%0d boot_go=%0d required 0 and 0", wrAddrQ.size(), bootCount);
      end
      checkAllZero("midreset_after");
   endtask

   initial begin
      tests    = 0;
      failures = 0;
      cycle    = 0;
      test_reset();
      test_basic_frame();
      test_wrap();
      test_partial();
      test_header_only();
      test_random();
      test_reset_mid_frame();
      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
